// File: rtl/tcb_unaligned_splitter.sv
// Splits unaligned LSB-aligned TCB manager transfers into word-aligned, byte-enabled subordinate transfers.
// Latency: aligned 1 sub transfer; a word-crossing access takes 2 sub transfers; response 1 cycle after the manager transfer.
// Backpressure: mgr_rdy_o follows sub_rdy_i combinationally, held low on the first half of a split.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   mgr_*_i / mgr_*_o     manager side: vld/rdy handshake, wen, adr (any alignment), siz (log2 bytes),
//                         wdt (LSB aligned) in; rdt (LSB aligned, zero above size), err out
//   sub_*_o / sub_*_i     subordinate side: vld/rdy handshake, wen, word adr, byte enables, lane-positioned wdt,
//                         lck (held on first half of a split) out; rdt, err in (valid 1 cycle after transfer)
module tcb_unaligned_splitter #(
  parameter  int unsigned ABW = 32,
  parameter  int unsigned DBW = 32,
  localparam int unsigned BEN = DBW / 8,
  localparam int unsigned OFW = $clog2(BEN),
  localparam int unsigned SZW = $clog2(OFW + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  // manager side
  input  logic           mgr_vld_i,
  output logic           mgr_rdy_o,
  input  logic           mgr_wen_i,
  input  logic [ABW-1:0] mgr_adr_i,
  input  logic [SZW-1:0] mgr_siz_i,
  input  logic [DBW-1:0] mgr_wdt_i,
  output logic [DBW-1:0] mgr_rdt_o,
  output logic           mgr_err_o,
  // subordinate side
  output logic           sub_vld_o,
  input  logic           sub_rdy_i,
  output logic           sub_wen_o,
  output logic [ABW-1:0] sub_adr_o,
  output logic [BEN-1:0] sub_byt_o,
  output logic [DBW-1:0] sub_wdt_o,
  output logic           sub_lck_o,
  input  logic [DBW-1:0] sub_rdt_i,
  input  logic           sub_err_i
);

  typedef enum logic {
    IDLE,
    SECOND
  } state_t;

  state_t           state_q;

  // first-half response capture
  logic             fst_q;
  logic [DBW-1:0]   buf_rdt_q;
  logic             buf_err_q;

  // response pipeline: shape of the manager transfer answered next cycle
  logic [OFW-1:0]   rsp_off_q;
  logic [SZW-1:0]   rsp_siz_q;
  logic             rsp_split_q;

  // request decode
  logic [OFW-1:0]   off;
  logic [OFW+1:0]   len;
  logic             split;
  logic [ABW-1:0]   adr_aln;
  logic [ABW-1:0]   adr_nxt;
  logic [2*BEN-1:0] ones_n;
  logic [2*BEN-1:0] byt2;
  logic [2*DBW-1:0] dat2;
  logic             mgr_rdy;
  logic             mgr_hs;
  logic             fst_hs;

  assign off     = mgr_adr_i[OFW-1:0];
  assign len     = (OFW+2)'(1) << mgr_siz_i;
  assign split   = ({2'b00, off} + len) > (OFW+2)'(BEN);
  assign adr_aln = {mgr_adr_i[ABW-1:OFW], {OFW{1'b0}}};
  assign adr_nxt = adr_aln + ABW'(BEN);

  always_comb begin
    ones_n = '0;
    for (int b = 0; b < 2*BEN; b++) begin
      ones_n[b] = (b < int'(len));
    end
  end

  // Shift into a double-width window: the low half is the current word,
  // the high half is what spills into the next word.
  assign byt2 = ones_n << off;
  assign dat2 = {{DBW{1'b0}}, mgr_wdt_i} << {off, 3'b000};

  always_comb begin
    sub_vld_o = 1'b0;
    mgr_rdy   = 1'b0;
    sub_adr_o = adr_aln;
    sub_byt_o = byt2[BEN-1:0];
    sub_wdt_o = dat2[DBW-1:0];
    sub_lck_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          sub_vld_o = mgr_vld_i;
          sub_lck_o = mgr_vld_i & split;
          mgr_rdy   = split ? 1'b0 : sub_rdy_i;
        end
        SECOND: begin
          // manager keeps its request stable until mgr_rdy, so the second half is always valid
          sub_vld_o = 1'b1;
          sub_adr_o = adr_nxt;
          sub_byt_o = byt2[2*BEN-1:BEN];
          sub_wdt_o = dat2[2*DBW-1:DBW];
          mgr_rdy   = sub_rdy_i;
        end
        default: ;
      endcase
    end
  end

  assign sub_wen_o = mgr_wen_i;
  assign mgr_rdy_o = mgr_rdy;
  assign mgr_hs    = mgr_vld_i & mgr_rdy;
  assign fst_hs    = (state_q == IDLE) & mgr_vld_i & sub_rdy_i & split & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      fst_q       <= 1'b0;
      buf_rdt_q   <= '0;
      buf_err_q   <= 1'b0;
      rsp_off_q   <= '0;
      rsp_siz_q   <= '0;
      rsp_split_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (fst_hs) state_q <= SECOND;
        SECOND:  if (sub_rdy_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      fst_q <= fst_hs;
      // the first-half response arrives the cycle after its transfer
      if (fst_q) begin
        buf_rdt_q <= sub_rdt_i;
        buf_err_q <= sub_err_i;
      end
      if (mgr_hs) begin
        rsp_off_q   <= off;
        rsp_siz_q   <= mgr_siz_i;
        rsp_split_q <= (state_q == SECOND);
      end
    end
  end

  // response merge
  logic [2*DBW-1:0] rsp_src;
  logic [2*DBW-1:0] rsp_shf;
  logic [OFW+1:0]   rsp_len;

  assign rsp_src = rsp_split_q ? {sub_rdt_i, buf_rdt_q} : {{DBW{1'b0}}, sub_rdt_i};
  assign rsp_shf = rsp_src >> {rsp_off_q, 3'b000};
  assign rsp_len = (OFW+2)'(1) << rsp_siz_q;

  always_comb begin
    mgr_rdt_o = '0;
    for (int b = 0; b < BEN; b++) begin
      if (b < int'(rsp_len)) mgr_rdt_o[8*b +: 8] = rsp_shf[8*b +: 8];
    end
  end

  assign mgr_err_o = sub_err_i | (rsp_split_q & buf_err_q);

endmodule
